// File: rtl/round_timer.sv
// Round/banner/pause timers and score keeping driven by the game FSM state code.
// Outputs are registered (one cycle after cause); no backpressure, strobes are single-cycle.
module round_timer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int ROUND_SECS    = 9
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] gameState,
  input  logic       POne_Increment,
  input  logic       PTwo_Increment,
  output logic [3:0] gameTime,
  output logic [1:0] readyTime,
  output logic [1:0] DiveKickTime,
  output logic [1:0] pauseTime,
  output logic [2:0] POne_Score,
  output logic [2:0] PTwo_Score,
  output logic [3:0] Round_Num
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 2;
  localparam logic [PW-1:0] PS_LAST    = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PS_HALF    = PW'(TICKS_PER_SEC / 2 - 1);
  localparam logic [3:0]    ROUND_INIT = 4'(ROUND_SECS);

  localparam logic [3:0] ST_TITLE    = 4'd0;
  localparam logic [3:0] ST_PLAYING  = 4'd3;
  localparam logic [3:0] ST_PAUSE    = 4'd4;
  localparam logic [3:0] ST_RESET    = 4'd5;
  localparam logic [3:0] ST_PAUSE2   = 4'd6;
  localparam logic [3:0] ST_READY    = 4'd8;
  localparam logic [3:0] ST_DIVEKICK = 4'd9;

  logic [3:0]    prev_state;
  logic [PW-1:0] prescaler;
  logic          entry;
  logic          sec_tick;
  logic          half_tick;
  logic          in_title;

  always_comb begin
    entry     = (gameState != prev_state);
    sec_tick  = (prescaler == PS_LAST) && !entry;
    half_tick = (prescaler == PS_HALF) || sec_tick;
    in_title  = (gameState == ST_TITLE);
  end

  // Prescaler restarts on every state entry so each state's first second is full length.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prev_state <= ST_TITLE;
      prescaler  <= '0;
    end else begin
      prev_state <= gameState;
      if (entry || prescaler == PS_LAST) prescaler <= '0;
      else                               prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      gameTime <= ROUND_INIT;
    end else if (in_title) begin
      gameTime <= ROUND_INIT;
    end else if (gameState == ST_READY && entry) begin
      gameTime <= ROUND_INIT;
    end else if (gameState == ST_PLAYING && sec_tick && gameTime != 4'd0) begin
      gameTime <= gameTime - 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      readyTime <= 2'd2;
    end else if (in_title) begin
      readyTime <= 2'd2;
    end else if (gameState == ST_READY) begin
      if (entry)                                readyTime <= 2'd2;
      else if (sec_tick && readyTime != 2'd0)   readyTime <= readyTime - 2'd1;
    end
  end

  // DiveKick banner counts in half seconds.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      DiveKickTime <= 2'd2;
    end else if (in_title) begin
      DiveKickTime <= 2'd2;
    end else if (gameState == ST_DIVEKICK) begin
      if (entry)                                   DiveKickTime <= 2'd2;
      else if (half_tick && DiveKickTime != 2'd0)  DiveKickTime <= DiveKickTime - 2'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pauseTime <= 2'd0;
    end else if (in_title) begin
      pauseTime <= 2'd0;
    end else if (gameState == ST_PAUSE2) begin
      if (entry)                               pauseTime <= 2'd0;
      else if (sec_tick && pauseTime != 2'd3)  pauseTime <= pauseTime + 2'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      POne_Score <= 3'd0;
      PTwo_Score <= 3'd0;
    end else if (in_title) begin
      POne_Score <= 3'd0;
      PTwo_Score <= 3'd0;
    end else if (gameState == ST_PAUSE) begin
      if (POne_Increment && POne_Score < 3'd5) POne_Score <= POne_Score + 3'd1;
      if (PTwo_Increment && PTwo_Score < 3'd5) PTwo_Score <= PTwo_Score + 3'd1;
    end
  end

  // A new round begins only when Ready is entered straight from the Reset state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Round_Num <= 4'd1;
    end else if (in_title) begin
      Round_Num <= 4'd1;
    end else if (gameState == ST_READY && entry && prev_state == ST_RESET
                 && Round_Num != 4'd15) begin
      Round_Num <= Round_Num + 4'd1;
    end
  end

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer with TICKS_PER_SEC=10, ROUND_SECS=9.
module tb_round_timer;

  logic       Clk;
  logic       Reset;
  logic [3:0] gameState;
  logic       POne_Increment;
  logic       PTwo_Increment;
  logic [3:0] gameTime;
  logic [1:0] readyTime;
  logic [1:0] DiveKickTime;
  logic [1:0] pauseTime;
  logic [2:0] POne_Score;
  logic [2:0] PTwo_Score;
  logic [3:0] Round_Num;

  int checks = 0;
  int errors = 0;

  round_timer #(.TICKS_PER_SEC(10), .ROUND_SECS(9)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .gameState(gameState),
    .POne_Increment(POne_Increment),
    .PTwo_Increment(PTwo_Increment),
    .gameTime(gameTime),
    .readyTime(readyTime),
    .DiveKickTime(DiveKickTime),
    .pauseTime(pauseTime),
    .POne_Score(POne_Score),
    .PTwo_Score(PTwo_Score),
    .Round_Num(Round_Num)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gameTime"},  32'(gameTime),     32'd9);
    chk({tag, "_readyTime"}, 32'(readyTime),    32'd2);
    chk({tag, "_diveTime"},  32'(DiveKickTime), 32'd2);
    chk({tag, "_pauseTime"}, 32'(pauseTime),    32'd0);
    chk({tag, "_p1"},        32'(POne_Score),   32'd0);
    chk({tag, "_p2"},        32'(PTwo_Score),   32'd0);
    chk({tag, "_round"},     32'(Round_Num),    32'd1);
  endtask

  initial begin
    Reset          = 1'b0;
    gameState      = 4'd0;
    POne_Increment = 1'b0;
    PTwo_Increment = 1'b0;
    step(3);
    chk_reset_vals("in_reset");
    Reset = 1'b1;
    step(3);
    chk_reset_vals("after_release");

    // Ready: 2 -> 1 -> 0 at one-second steps
    gameState = 4'd8;
    step(1);
    chk("ready_entry", 32'(readyTime), 32'd2);
    chk("ready_gt", 32'(gameTime), 32'd9);
    step(9);
    chk("ready_9cyc", 32'(readyTime), 32'd2);
    step(1);
    chk("ready_10cyc", 32'(readyTime), 32'd1);
    step(10);
    chk("ready_20cyc", 32'(readyTime), 32'd0);
    chk("ready_gt_hold", 32'(gameTime), 32'd9);
    step(10);
    chk("ready_sat", 32'(readyTime), 32'd0);
    chk("ready_round", 32'(Round_Num), 32'd1);

    // DiveKick: half-second steps
    gameState = 4'd9;
    step(1);
    chk("dive_entry", 32'(DiveKickTime), 32'd2);
    step(4);
    chk("dive_4cyc", 32'(DiveKickTime), 32'd2);
    step(1);
    chk("dive_5cyc", 32'(DiveKickTime), 32'd1);
    step(5);
    chk("dive_10cyc", 32'(DiveKickTime), 32'd0);
    step(10);
    chk("dive_sat", 32'(DiveKickTime), 32'd0);

    // Playing: countdown 9..0
    gameState = 4'd3;
    step(1);
    chk("play_entry", 32'(gameTime), 32'd9);
    for (int k = 1; k <= 9; k++) begin
      step(10);
      chk("play_count", 32'(gameTime), 32'(9 - k));
    end
    step(20);
    chk("play_sat", 32'(gameTime), 32'd0);
    POne_Increment = 1'b1;
    PTwo_Increment = 1'b1;
    step(1);
    POne_Increment = 1'b0;
    PTwo_Increment = 1'b0;
    step(1);
    chk("play_strobe_p1", 32'(POne_Score), 32'd0);
    chk("play_strobe_p2", 32'(PTwo_Score), 32'd0);
    chk("play_dive_hold", 32'(DiveKickTime), 32'd0);

    // Pause: both strobes, six rounds through Pause2
    for (int r = 1; r <= 6; r++) begin
      gameState = 4'd4;
      step(2);
      POne_Increment = 1'b1;
      PTwo_Increment = 1'b1;
      step(1);
      POne_Increment = 1'b0;
      PTwo_Increment = 1'b0;
      chk("pause_p1", 32'(POne_Score), 32'((r > 5) ? 5 : r));
      chk("pause_p2", 32'(PTwo_Score), 32'((r > 5) ? 5 : r));
      gameState = 4'd6;
      step(2);
    end
    chk("pause_gt_hold", 32'(gameTime), 32'd0);

    // Pause2: 0..3 saturating
    gameState = 4'd4;
    step(2);
    gameState = 4'd6;
    step(1);
    chk("p2_entry", 32'(pauseTime), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step(10);
      chk("p2_count", 32'(pauseTime), 32'(k));
    end
    step(10);
    chk("p2_sat", 32'(pauseTime), 32'd3);

    // Reset state holds everything, then Ready bumps the round
    gameState = 4'd5;
    step(12);
    chk("rst_hold_pause", 32'(pauseTime), 32'd3);
    chk("rst_hold_p1", 32'(POne_Score), 32'd5);
    chk("rst_hold_gt", 32'(gameTime), 32'd0);
    gameState = 4'd8;
    step(1);
    chk("new_round", 32'(Round_Num), 32'd2);
    chk("new_round_gt", 32'(gameTime), 32'd9);
    chk("new_round_ready", 32'(readyTime), 32'd2);

    // Title clears scores and round
    gameState = 4'd0;
    step(2);
    chk("title_p1", 32'(POne_Score), 32'd0);
    chk("title_round", 32'(Round_Num), 32'd1);
    chk("title_pause", 32'(pauseTime), 32'd0);

    // Single-player strobes: P1 to 3
    gameState = 4'd4;
    step(2);
    for (int i = 0; i < 3; i++) begin
      POne_Increment = 1'b1;
      step(1);
      POne_Increment = 1'b0;
      step(1);
    end
    chk("single_p1", 32'(POne_Score), 32'd3);
    chk("single_p2", 32'(PTwo_Score), 32'd0);

    gameState = 4'd8;
    step(1);
    chk("no_round_bump", 32'(Round_Num), 32'd1);
    gameState = 4'd3;
    step(1);
    step(50);
    chk("mid_play_gt", 32'(gameTime), 32'd4);

    // Asynchronous reset mid-round
    @(posedge Clk);
    #3 Reset = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    step(3);
    Reset = 1'b1;
    step(1);
    chk("fresh_entry", 32'(gameTime), 32'd9);
    step(9);
    chk("fresh_9cyc", 32'(gameTime), 32'd9);
    step(1);
    chk("fresh_10cyc", 32'(gameTime), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
